// File: rtl/audio_pkg.sv
// Shared constants and helpers for the audio frame retimer and its lanes.
package audio_pkg;

   localparam int DEF_CH        = 2;
   localparam int DEF_DW        = 24;
   localparam int DEF_FRAME_LEN = 256;

   // Frame counter width; a 1-bit floor keeps tiny frames legal.
   function automatic int cnt_width(input int frame_len);
      return (frame_len <= 2) ? 1 : $clog2(frame_len);
   endfunction

   localparam int DEF_CNT_W = cnt_width(DEF_FRAME_LEN);

   // Channel c is emitted at the end of the frame minus c equal sub-frames.
   function automatic int slot_of(input int c, input int ch, input int frame_len);
      return frame_len - 1 - c * (frame_len / ch);
   endfunction

endpackage

// File: rtl/audio_frame_retimer_if.sv
// Sample bus between an upstream producer, the retimer and the serialiser.
interface audio_frame_retimer_if #(
   parameter int CH = 2,
   parameter int DW = 24
);
   logic [CH*DW-1:0] DATA_IN;
   logic [CH-1:0]    SAMPLING_POINT_IN;
   logic             MUTE_IN;
   logic             STATUS_CLR;
   logic [CH*DW-1:0] DATA_OUT;
   logic [CH-1:0]    SAMPLING_POINT_OUT;
   logic             FRAME_SYNC;
   logic [CH-1:0]    UNDERRUN;
   logic [CH-1:0]    OVERRUN;

   modport master (
      output DATA_IN, SAMPLING_POINT_IN, MUTE_IN, STATUS_CLR,
      input  DATA_OUT, SAMPLING_POINT_OUT, FRAME_SYNC, UNDERRUN, OVERRUN
   );

   modport slave (
      input  DATA_IN, SAMPLING_POINT_IN, MUTE_IN, STATUS_CLR,
      output DATA_OUT, SAMPLING_POINT_OUT, FRAME_SYNC, UNDERRUN, OVERRUN
   );
endinterface

// File: rtl/audio_retimer_lane.sv
// One channel: capture register, freshness tracking, fill/mute mux and sticky flags.
module audio_retimer_lane #(
   parameter int DW            = 24,
   parameter int UNDERRUN_ZERO = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] din,
   input  logic          cap_stb,
   input  logic          slot_hit,
   input  logic          mute,
   input  logic          status_clr,
   output logic [DW-1:0] dout,
   output logic          stb,
   output logic          underrun,
   output logic          overrun
);

   logic [DW-1:0] cap_q, cap_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          fresh_q, fresh_d;
   logic          primed_q, primed_d;
   logic          stb_q, stb_d;
   logic          ur_q, ur_d;
   logic          ovr_q, ovr_d;

   always_comb begin
      cap_d    = cap_q;
      dout_d   = dout_q;
      fresh_d  = fresh_q;
      primed_d = primed_q;
      stb_d    = 1'b0;
      ur_d     = ur_q & ~status_clr;
      ovr_d    = ovr_q & ~status_clr;

      // Slot evaluation sees the pre-edge capture state, so a same-cycle
      // capture lands in the next frame.
      if (slot_hit) begin
         stb_d   = 1'b1;
         fresh_d = 1'b0;
         if (mute)
            dout_d = '0;
         else if (!fresh_q && (UNDERRUN_ZERO != 0))
            dout_d = '0;
         else
            dout_d = cap_q;
         if (!fresh_q && primed_q)
            ur_d = 1'b1;
      end

      if (cap_stb) begin
         cap_d    = din;
         fresh_d  = 1'b1;
         primed_d = 1'b1;
         if (fresh_q && !slot_hit)
            ovr_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cap_q    <= '0;
         dout_q   <= '0;
         fresh_q  <= 1'b0;
         primed_q <= 1'b0;
         stb_q    <= 1'b0;
         ur_q     <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         cap_q    <= cap_d;
         dout_q   <= dout_d;
         fresh_q  <= fresh_d;
         primed_q <= primed_d;
         stb_q    <= stb_d;
         ur_q     <= ur_d;
         ovr_q    <= ovr_d;
      end
   end

   assign dout     = dout_q;
   assign stb      = stb_q;
   assign underrun = ur_q;
   assign overrun  = ovr_q;

endmodule

// File: rtl/audio_frame_retimer.sv
// Multi-channel audio retimer: free-running frame counter, per-channel slot decode
// and frame sync; per-channel state lives in audio_retimer_lane.
module audio_frame_retimer
   import audio_pkg::*;
#(
   parameter int CH            = DEF_CH,
   parameter int DW            = DEF_DW,
   parameter int FRAME_LEN     = DEF_FRAME_LEN,
   parameter int UNDERRUN_ZERO = 0
) (
   input  logic                  ck98M,
   input  logic                  RESET,
   audio_frame_retimer_if.slave  bus
);

   localparam int CNT_W = cnt_width(FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CH-1:0]          slot_hit;
   logic [CH-1:0][DW-1:0]  lane_dout;
   logic [CH-1:0]          lane_stb;
   logic [CH-1:0]          lane_ur;
   logic [CH-1:0]          lane_ovr;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST)
         cnt_d = '0;
   end

   always_ff @(posedge ck98M) begin
      if (RESET)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   for (genvar c = 0; c < CH; c++) begin : g_lane
      localparam logic [CNT_W-1:0] SLOT = CNT_W'(slot_of(c, CH, FRAME_LEN));

      assign slot_hit[c] = (cnt_q == SLOT);

      audio_retimer_lane #(
         .DW            (DW),
         .UNDERRUN_ZERO (UNDERRUN_ZERO)
      ) u_lane (
         .clk        (ck98M),
         .rst        (RESET),
         .din        (bus.DATA_IN[c*DW +: DW]),
         .cap_stb    (bus.SAMPLING_POINT_IN[c]),
         .slot_hit   (slot_hit[c]),
         .mute       (bus.MUTE_IN),
         .status_clr (bus.STATUS_CLR),
         .dout       (lane_dout[c]),
         .stb        (lane_stb[c]),
         .underrun   (lane_ur[c]),
         .overrun    (lane_ovr[c])
      );
   end

   // Packed lane array flattens with channel c at [c*DW +: DW].
   assign bus.DATA_OUT           = lane_dout;
   assign bus.SAMPLING_POINT_OUT = lane_stb;
   assign bus.UNDERRUN           = lane_ur;
   assign bus.OVERRUN            = lane_ovr;
   assign bus.FRAME_SYNC         = (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_audio_frame_retimer.sv
// Directed bench: repeat-fill 2-ch DUT, zero-fill 2-ch DUT and a 4-ch/64-clock DUT.
module tb_audio_frame_retimer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   audio_frame_retimer_if #(.CH(2), .DW(24)) b0 ();
   audio_frame_retimer_if #(.CH(2), .DW(24)) b1 ();
   audio_frame_retimer_if #(.CH(4), .DW(8))  b2 ();

   audio_frame_retimer #(.CH(2), .DW(24), .FRAME_LEN(256), .UNDERRUN_ZERO(0))
      d0 (.ck98M(clk), .RESET(rst), .bus(b0));
   audio_frame_retimer #(.CH(2), .DW(24), .FRAME_LEN(256), .UNDERRUN_ZERO(1))
      d1 (.ck98M(clk), .RESET(rst), .bus(b1));
   audio_frame_retimer #(.CH(4), .DW(8), .FRAME_LEN(64), .UNDERRUN_ZERO(0))
      d2 (.ck98M(clk), .RESET(rst), .bus(b2));

   // Reference frame position; 256 is a multiple of 64 so d2 sits at tcnt % 64.
   logic [7:0] tcnt;
   always @(posedge clk) begin
      if (rst) tcnt <= 8'd0;
      else     tcnt <= tcnt + 8'd1;
   end

   int errors = 0;
   int checks = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cnt(input int v);
      int n = 0;
      while (int'(tcnt) != v && n < 600) begin
         tick();
         n++;
      end
      if (int'(tcnt) != v) begin
         checks++;
         errors++;
         $display("FAIL wait_cnt: got count %0d required %0d", tcnt, v);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (b0.DATA_OUT !== 48'h0 || b0.SAMPLING_POINT_OUT !== 2'b00 || b0.FRAME_SYNC !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got data=%h sp=%b fs=%b required 0", b0.DATA_OUT, b0.SAMPLING_POINT_OUT, b0.FRAME_SYNC);
      end
      checks++;
      if (b0.UNDERRUN !== 2'b00 || b0.OVERRUN !== 2'b00) begin
         errors++;
         $display("FAIL reset_flags: got ur=%b ov=%b required 00 00", b0.UNDERRUN, b0.OVERRUN);
      end
      rst = 1'b0;
      // Slots before any capture must strobe but not flag.
      wait_cnt(255);
      tick();
      checks++;
      if (b0.SAMPLING_POINT_OUT !== 2'b01 || b0.DATA_OUT[23:0] !== 24'h0) begin
         errors++;
         $display("FAIL unprimed_slot: got sp=%b d0=%h required 01 000000", b0.SAMPLING_POINT_OUT, b0.DATA_OUT[23:0]);
      end
      checks++;
      if (b0.UNDERRUN !== 2'b00 || b1.UNDERRUN !== 2'b00) begin
         errors++;
         $display("FAIL unprimed_noflag: got ur0=%b ur1=%b required 00 00", b0.UNDERRUN, b1.UNDERRUN);
      end
   endtask

   task automatic test_pass_through();
      wait_cnt(10);
      b0.DATA_IN[23:0] = 24'h123456;
      b0.SAMPLING_POINT_IN = 2'b01;
      tick();
      b0.SAMPLING_POINT_IN = 2'b00;
      wait_cnt(20);
      b0.DATA_IN[47:24] = 24'hABCDEF;
      b0.SAMPLING_POINT_IN = 2'b10;
      tick();
      b0.SAMPLING_POINT_IN = 2'b00;
      wait_cnt(127);
      checks++;
      if (b0.SAMPLING_POINT_OUT !== 2'b00) begin
         errors++;
         $display("FAIL pt_early: got sp=%b required 00", b0.SAMPLING_POINT_OUT);
      end
      tick();
      checks++;
      if (b0.SAMPLING_POINT_OUT !== 2'b10 || b0.DATA_OUT[47:24] !== 24'hABCDEF) begin
         errors++;
         $display("FAIL pt_ch1: got sp=%b d1=%h required 10 abcdef", b0.SAMPLING_POINT_OUT, b0.DATA_OUT[47:24]);
      end
      tick();
      checks++;
      if (b0.SAMPLING_POINT_OUT !== 2'b00 || b0.DATA_OUT[47:24] !== 24'hABCDEF) begin
         errors++;
         $display("FAIL pt_hold: got sp=%b d1=%h required 00 abcdef", b0.SAMPLING_POINT_OUT, b0.DATA_OUT[47:24]);
      end
      wait_cnt(255);
      checks++;
      if (b0.FRAME_SYNC !== 1'b1) begin
         errors++;
         $display("FAIL pt_fsync: got %b required 1", b0.FRAME_SYNC);
      end
      tick();
      checks++;
      if (b0.SAMPLING_POINT_OUT !== 2'b01 || b0.DATA_OUT[23:0] !== 24'h123456 || b0.FRAME_SYNC !== 1'b0) begin
         errors++;
         $display("FAIL pt_ch0: got sp=%b d0=%h fs=%b required 01 123456 0", b0.SAMPLING_POINT_OUT, b0.DATA_OUT[23:0], b0.FRAME_SYNC);
      end
      checks++;
      if (b0.UNDERRUN !== 2'b00 || b0.OVERRUN !== 2'b00) begin
         errors++;
         $display("FAIL pt_flags: got ur=%b ov=%b required 00 00", b0.UNDERRUN, b0.OVERRUN);
      end
   endtask

   task automatic test_underrun();
      wait_cnt(50);
      b0.DATA_IN[23:0] = 24'h000111;
      b1.DATA_IN[23:0] = 24'h000111;
      b0.SAMPLING_POINT_IN = 2'b01;
      b1.SAMPLING_POINT_IN = 2'b01;
      tick();
      b0.SAMPLING_POINT_IN = 2'b00;
      b1.SAMPLING_POINT_IN = 2'b00;
      wait_cnt(255);
      tick();
      checks++;
      if (b0.DATA_OUT[23:0] !== 24'h000111 || b1.DATA_OUT[23:0] !== 24'h000111 || b0.UNDERRUN[0] !== 1'b0) begin
         errors++;
         $display("FAIL ur_fresh: got d0=%h d1=%h ur0=%b required 000111 000111 0", b0.DATA_OUT[23:0], b1.DATA_OUT[23:0], b0.UNDERRUN[0]);
      end
      wait_cnt(255);
      tick();
      checks++;
      if (b0.SAMPLING_POINT_OUT[0] !== 1'b1 || b0.DATA_OUT[23:0] !== 24'h000111 || b0.UNDERRUN !== 2'b11) begin
         errors++;
         $display("FAIL ur_repeat: got sp0=%b d=%h ur=%b required 1 000111 11", b0.SAMPLING_POINT_OUT[0], b0.DATA_OUT[23:0], b0.UNDERRUN);
      end
      checks++;
      if (b1.SAMPLING_POINT_OUT[0] !== 1'b1 || b1.DATA_OUT[23:0] !== 24'h0 || b1.UNDERRUN !== 2'b01) begin
         errors++;
         $display("FAIL ur_zero: got sp0=%b d=%h ur=%b required 1 000000 01", b1.SAMPLING_POINT_OUT[0], b1.DATA_OUT[23:0], b1.UNDERRUN);
      end
      wait_cnt(5);
      b0.STATUS_CLR = 1'b1;
      tick();
      b0.STATUS_CLR = 1'b0;
      checks++;
      if (b0.UNDERRUN !== 2'b00) begin
         errors++;
         $display("FAIL ur_clear: got ur=%b required 00", b0.UNDERRUN);
      end
   endtask

   task automatic test_overrun();
      wait_cnt(130);
      b0.DATA_IN[47:24] = 24'h000001;
      b0.SAMPLING_POINT_IN = 2'b10;
      tick();
      b0.SAMPLING_POINT_IN = 2'b00;
      wait_cnt(140);
      b0.DATA_IN[47:24] = 24'h000002;
      b0.SAMPLING_POINT_IN = 2'b10;
      tick();
      b0.SAMPLING_POINT_IN = 2'b00;
      checks++;
      if (b0.OVERRUN !== 2'b10) begin
         errors++;
         $display("FAIL ov_set: got ov=%b required 10", b0.OVERRUN);
      end
      wait_cnt(127);
      tick();
      checks++;
      if (b0.SAMPLING_POINT_OUT[1] !== 1'b1 || b0.DATA_OUT[47:24] !== 24'h000002) begin
         errors++;
         $display("FAIL ov_newest: got sp1=%b d1=%h required 1 000002", b0.SAMPLING_POINT_OUT[1], b0.DATA_OUT[47:24]);
      end
      wait_cnt(150);
      b0.STATUS_CLR = 1'b1;
      tick();
      b0.STATUS_CLR = 1'b0;
      checks++;
      if (b0.OVERRUN !== 2'b00) begin
         errors++;
         $display("FAIL ov_clear: got ov=%b required 00", b0.OVERRUN);
      end
      wait_cnt(160);
      b0.DATA_IN[47:24] = 24'h000003;
      b0.SAMPLING_POINT_IN = 2'b10;
      tick();
      b0.SAMPLING_POINT_IN = 2'b00;
      wait_cnt(170);
      b0.DATA_IN[47:24] = 24'h000004;
      b0.SAMPLING_POINT_IN = 2'b10;
      b0.STATUS_CLR = 1'b1;
      tick();
      b0.SAMPLING_POINT_IN = 2'b00;
      b0.STATUS_CLR = 1'b0;
      checks++;
      if (b0.OVERRUN !== 2'b10) begin
         errors++;
         $display("FAIL ov_event_wins: got ov=%b required 10", b0.OVERRUN);
      end
   endtask

   task automatic test_collision();
      wait_cnt(200);
      b0.DATA_IN[23:0] = 24'h000055;
      b0.SAMPLING_POINT_IN = 2'b01;
      tick();
      b0.SAMPLING_POINT_IN = 2'b00;
      wait_cnt(210);
      b0.STATUS_CLR = 1'b1;
      tick();
      b0.STATUS_CLR = 1'b0;
      wait_cnt(255);
      b0.DATA_IN[23:0] = 24'h0000AA;
      b0.SAMPLING_POINT_IN = 2'b01;
      tick();
      b0.SAMPLING_POINT_IN = 2'b00;
      checks++;
      if (b0.SAMPLING_POINT_OUT[0] !== 1'b1 || b0.DATA_OUT[23:0] !== 24'h000055 || b0.OVERRUN !== 2'b00) begin
         errors++;
         $display("FAIL col_old: got sp0=%b d0=%h ov=%b required 1 000055 00", b0.SAMPLING_POINT_OUT[0], b0.DATA_OUT[23:0], b0.OVERRUN);
      end
      wait_cnt(255);
      tick();
      checks++;
      if (b0.DATA_OUT[23:0] !== 24'h0000AA || b0.UNDERRUN !== 2'b00 || b0.OVERRUN !== 2'b00) begin
         errors++;
         $display("FAIL col_new: got d0=%h ur=%b ov=%b required 0000aa 00 00", b0.DATA_OUT[23:0], b0.UNDERRUN, b0.OVERRUN);
      end
   endtask

   task automatic test_mute();
      wait_cnt(10);
      b0.MUTE_IN = 1'b1;
      b0.DATA_IN[47:24] = 24'h000777;
      b0.SAMPLING_POINT_IN = 2'b10;
      tick();
      b0.SAMPLING_POINT_IN = 2'b00;
      wait_cnt(127);
      tick();
      b0.MUTE_IN = 1'b0;
      checks++;
      if (b0.SAMPLING_POINT_OUT[1] !== 1'b1 || b0.DATA_OUT[47:24] !== 24'h0) begin
         errors++;
         $display("FAIL mute_zero: got sp1=%b d1=%h required 1 000000", b0.SAMPLING_POINT_OUT[1], b0.DATA_OUT[47:24]);
      end
      wait_cnt(127);
      tick();
      checks++;
      if (b0.DATA_OUT[47:24] !== 24'h000777 || b0.UNDERRUN[1] !== 1'b1) begin
         errors++;
         $display("FAIL mute_after: got d1=%h ur1=%b required 000777 1", b0.DATA_OUT[47:24], b0.UNDERRUN[1]);
      end
   endtask

   task automatic test_generic();
      wait_cnt(1);
      b2.DATA_IN = 32'h44332211;
      b2.SAMPLING_POINT_IN = 4'b1111;
      tick();
      b2.SAMPLING_POINT_IN = 4'b0000;
      wait_cnt(16);
      checks++;
      if (b2.SAMPLING_POINT_OUT !== 4'b1000 || b2.DATA_OUT[31:24] !== 8'h44) begin
         errors++;
         $display("FAIL gen_ch3: got sp=%b d3=%h required 1000 44", b2.SAMPLING_POINT_OUT, b2.DATA_OUT[31:24]);
      end
      tick();
      checks++;
      if (b2.SAMPLING_POINT_OUT !== 4'b0000) begin
         errors++;
         $display("FAIL gen_width: got sp=%b required 0000", b2.SAMPLING_POINT_OUT);
      end
      wait_cnt(32);
      checks++;
      if (b2.SAMPLING_POINT_OUT !== 4'b0100 || b2.DATA_OUT[23:16] !== 8'h33) begin
         errors++;
         $display("FAIL gen_ch2: got sp=%b d2=%h required 0100 33", b2.SAMPLING_POINT_OUT, b2.DATA_OUT[23:16]);
      end
      wait_cnt(48);
      checks++;
      if (b2.SAMPLING_POINT_OUT !== 4'b0010 || b2.DATA_OUT[15:8] !== 8'h22) begin
         errors++;
         $display("FAIL gen_ch1: got sp=%b d1=%h required 0010 22", b2.SAMPLING_POINT_OUT, b2.DATA_OUT[15:8]);
      end
      wait_cnt(63);
      checks++;
      if (b2.FRAME_SYNC !== 1'b1) begin
         errors++;
         $display("FAIL gen_fsync: got %b required 1", b2.FRAME_SYNC);
      end
      tick();
      checks++;
      if (b2.SAMPLING_POINT_OUT !== 4'b0001 || b2.DATA_OUT[7:0] !== 8'h11) begin
         errors++;
         $display("FAIL gen_ch0: got sp=%b d0=%h required 0001 11", b2.SAMPLING_POINT_OUT, b2.DATA_OUT[7:0]);
      end
   endtask

   task automatic test_reset_mid();
      wait_cnt(100);
      rst = 1'b1;
      tick();
      checks++;
      if (b0.DATA_OUT !== 48'h0 || b0.SAMPLING_POINT_OUT !== 2'b00 || b0.UNDERRUN !== 2'b00 || b0.OVERRUN !== 2'b00) begin
         errors++;
         $display("FAIL rst_mid: got data=%h sp=%b ur=%b ov=%b required 0", b0.DATA_OUT, b0.SAMPLING_POINT_OUT, b0.UNDERRUN, b0.OVERRUN);
      end
      rst = 1'b0;
      repeat (127) tick();
      checks++;
      if (b0.SAMPLING_POINT_OUT !== 2'b00) begin
         errors++;
         $display("FAIL rst_early: got sp=%b required 00", b0.SAMPLING_POINT_OUT);
      end
      tick();
      checks++;
      if (b0.SAMPLING_POINT_OUT !== 2'b10 || b0.DATA_OUT !== 48'h0 || b0.UNDERRUN !== 2'b00) begin
         errors++;
         $display("FAIL rst_restart: got sp=%b data=%h ur=%b required 10 0 00", b0.SAMPLING_POINT_OUT, b0.DATA_OUT, b0.UNDERRUN);
      end
   endtask

   initial begin
      b0.DATA_IN = '0; b0.SAMPLING_POINT_IN = '0; b0.MUTE_IN = 1'b0; b0.STATUS_CLR = 1'b0;
      b1.DATA_IN = '0; b1.SAMPLING_POINT_IN = '0; b1.MUTE_IN = 1'b0; b1.STATUS_CLR = 1'b0;
      b2.DATA_IN = '0; b2.SAMPLING_POINT_IN = '0; b2.MUTE_IN = 1'b0; b2.STATUS_CLR = 1'b0;
      test_reset();
      test_pass_through();
      test_underrun();
      test_overrun();
      test_collision();
      test_mute();
      test_generic();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/audio_frame_retimer.md
Name: audio_frame_retimer

Overview:
- Multi-channel successor of the single-pair audio pass-through stage.
- Captures one sample per channel on that channel's input strobe and re-emits it at a fixed slot inside a free-running frame of FRAME_LEN clocks.
- Adds per-channel freshness tracking, underrun and overrun detection with sticky flags, an underrun fill mode, a mute input and a frame-sync output.
- Sits between any upstream producer (FFT post-processing, filters) and the audio output serialiser.

Parameters:
- CH, 2: number of channels (≥1).
- DW, 24: sample width in bits.
- FRAME_LEN, 256: clocks per output frame. Must be a multiple of CH and ≥2*CH.
- UNDERRUN_ZERO, 0: fill value on underrun. 0 = repeat last sample; 1 = emit zero.

Ports:
- ck98M  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- DATA_IN  in  CH*DW  flattened input samples; channel c occupies [c*DW +: DW].
- SAMPLING_POINT_IN  in  CH  per-channel capture strobe, one clock wide.
- MUTE_IN  in  1  when high, output samples are forced to zero; strobes are unaffected.
- STATUS_CLR  in  1  one-clock clear of the sticky status flags.
- DATA_OUT  out  CH*DW  flattened output samples, registered.
- SAMPLING_POINT_OUT  out  CH  per-channel output strobe, one clock wide.
- FRAME_SYNC  out  1  high for one clock when frame counter = FRAME_LEN-1.
- UNDERRUN  out  CH  sticky per-channel underrun flag.
- OVERRUN  out  CH  sticky per-channel overrun flag.

Behaviour:
- Reset (synchronous): frame counter=0; all outputs=0; capture registers=0; fresh=0; primed=0 for every channel.
- Frame counter: width $clog2(FRAME_LEN). Increments every clock and wraps FRAME_LEN-1 -> 0.
- Slot of channel c: SLOT(c) = FRAME_LEN-1 - c*(FRAME_LEN/CH). With CH=2 and FRAME_LEN=256, ch0 is at 255 and ch1 at 127.
- Capture: SAMPLING_POINT_IN[c] high means cap[c] <= DATA_IN slice; fresh[c] <= 1; primed[c] <= 1.
- Output: when counter == SLOT(c), on the next edge:
  - SAMPLING_POINT_OUT[c] = 1 for one clock.
  - DATA_OUT slice = 0 if MUTE_IN is high.
  - Otherwise it is cap[c] if fresh[c], else (UNDERRUN_ZERO ? 0 : cap[c]).
  - fresh[c] is cleared.
  - Strobe and data appear one clock after the slot count; the data changes only on a strobe.
- Latency: a sample captured at edge t is eligible for any slot evaluated at edge t+1 or later.
- Capture and slot in the same clock for the same channel:
  - The output uses the previous cap[c] and fresh[c].
  - The new sample is stored with fresh[c]=1 for the next frame.
  - No overrun is raised.
- Overrun: a capture while fresh[c]=1, outside the slot cycle, sets OVERRUN[c]. Newest data wins.
- Underrun: a slot with fresh[c]=0 and primed[c]=1 sets UNDERRUN[c]. Slots before the first capture after reset do not flag.
- STATUS_CLR clears all sticky flags. An event in the same clock wins, so the flag stays set.
- MUTE_IN is sampled at the slot clock. It does not affect fresh, primed or flag logic.
- Reset mid-frame: counter, outputs and state return to their reset values at that edge. No strobe is emitted in the reset cycle.
- Channels are independent; simultaneous strobes on several channels are legal.

Decomposition:
- Shared package audio_pkg holds:
  - default DW/CH/FRAME_LEN constants;
  - a slot-offset helper function;
  - counter-width localparam derivation.
- One sub-module, audio_retimer_lane. It is instantiated CH times and contains the capture register, fresh/primed bits, fill/mute mux and sticky flags. It takes the slot-hit pulse and STATUS_CLR as inputs.
- The top level holds the frame counter, slot decode and FRAME_SYNC.

Test Plan (CH=2, DW=24, FRAME_LEN=256 unless noted):
- Pass-through: after reset, capture ch0=24'h123456 at count 10 and ch1=24'hABCDEF at count 20. Required: ch1 strobe with ABCDEF one clock after count 127; ch0 strobe with 123456 one clock after count 255; FRAME_SYNC at 255; no flags.
- Underrun: stop ch0 captures after one sample 24'h000111. Next ch0 slot repeats 000111 and sets UNDERRUN[0]. With UNDERRUN_ZERO=1 it outputs 0. Before any capture, no flag is set.
- Overrun: two ch1 captures, 24'h000001 then 24'h000002, between slots. Required: OVERRUN[1]=1 and the slot outputs 000002. STATUS_CLR clears it, but not when a new overrun lands in the same clock.
- Collision: ch0 capture at count 255 with 24'h0000AA while old fresh value is 24'h000055. Required: output 000055 now and 0000AA next frame; no overrun.
- Mute/reset: MUTE_IN=1 gives zero data with strobes intact. RESET asserted at count 100 returns counter and outputs to 0, and the next ch1 strobe occurs after count 127 of the restarted frame.
- Generic: CH=4, FRAME_LEN=64 gives strobes after counts 63, 47, 31 and 15 for ch0..ch3.
